// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshakes, bit-serial shifts and an optional multiplier.
// Define ALU_MUL_EN to build opcode 1011 as a WIDTH-cycle shift-add multiply.
module alu_mc #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Z,
  output logic             busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;

  localparam logic [WIDTH-1:0] PATTERN = {(WIDTH/2){2'b01}};

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   opA_q, opA_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [3:0]         op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic               isShift;
  logic [WIDTH-1:0]   simpleResult;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'b1011;
  logic [WIDTH-1:0] acc_q, acc_d, accNext;
  logic             isMul, isMulIn;

  assign isMul   = (op_q == OP_MUL);
  assign isMulIn = (ALUControl == OP_MUL);
  assign accNext = acc_q + (opB_q[0] ? opA_q : '0);
`endif

  assign isShift = (op_q == OP_SLL) || (op_q == OP_SRL) || (op_q == OP_SRA);

  // Shift ops have already been stepped into opA_q by the time they reach this mux.
  always_comb begin
    simpleResult = PATTERN;
    case (op_q)
      OP_ADD:  simpleResult = opA_q + opB_q;
      OP_SUB:  simpleResult = opA_q + ~opB_q + WIDTH'(1);
      OP_AND:  simpleResult = opA_q & opB_q;
      OP_XOR:  simpleResult = opA_q ^ opB_q;
      OP_SLT:  simpleResult = {{(WIDTH-1){1'b0}}, ($signed(opA_q) < $signed(opB_q))};
      OP_OR:   simpleResult = opA_q | opB_q;
      OP_SLL, OP_SRL, OP_SRA: simpleResult = opA_q;
      OP_SLTU: simpleResult = {{(WIDTH-1){1'b0}}, (opA_q < opB_q)};
      default: simpleResult = PATTERN;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_MUL_EN
    acc_d    = acc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = a_in;
          opB_d   = b_in;
          op_d    = ALUControl;
          cnt_d   = b_in[SHAMT_W-1:0];
          state_d = EXEC;
`ifdef ALU_MUL_EN
          acc_d   = '0;
          if (isMulIn) cnt_d = SHAMT_W'(WIDTH-1);
`endif
        end
      end
      EXEC: begin
`ifdef ALU_MUL_EN
        if (isMul) begin
          acc_d = accNext;
          opA_d = opA_q << 1;
          opB_d = opB_q >> 1;
          cnt_d = cnt_q - SHAMT_W'(1);
          if (cnt_q == '0) begin
            result_d = accNext;
            zero_d   = (accNext == '0);
            state_d  = DONE;
          end
        end else
`endif
        if (isShift && (cnt_q != '0)) begin
          case (op_q)
            OP_SLL:  opA_d = opA_q << 1;
            OP_SRL:  opA_d = opA_q >> 1;
            default: opA_d = {opA_q[WIDTH-1], opA_q[WIDTH-1:1]};
          endcase
          cnt_d = cnt_q - SHAMT_W'(1);
        end else begin
          result_d = simpleResult;
          zero_d   = (simpleResult == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifdef ALU_MUL_EN
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_MUL_EN
      acc_q    <= acc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign ALUResult = result_q;
  assign Z         = zero_q;

endmodule
